btn_press_decoder: RTL and testbench

Consumes the clean, single-clock-domain level from the button debouncer and classifies each press into one-cycle event pulses: short press, long press, double press, and auto-repeat while a long press is held. It sits directly downstream of the debouncer and feeds the UI/control logic, which then never has to time button levels itself. All outputs are registered.

---
 rtl/btn_press_decoder.sv | 141 ++++++++++++++
 tb/tb_btn_press_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_press_decoder.sv
// btn_press_decoder: classifies debounced button presses into one-cycle event
// pulses (short, long, double, auto-repeat while held after a long press).
//
// Ports:
//   clk           clock
//   reset         asynchronous, active-high reset
//   db            debounced button level, synchronous to clk, 1 = pressed
//   pressed       db delayed one cycle
//   short_press   pulse: single press released, no second press in the window
//   long_press    pulse: press held LONG_CYCLES samples
//   double_press  pulse: second press released inside the window
//   repeat_pulse  pulse every REPEAT_CYCLES held samples after long_press
module btn_press_decoder #(
    parameter int unsigned LONG_CYCLES   = 16,
    parameter int unsigned GAP_CYCLES    = 8,
    parameter int unsigned REPEAT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic db,
    output logic pressed,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_pulse
);

    localparam int unsigned MAX_LG     = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
    localparam int unsigned CNT_W      = 32'($clog2(MAX_CYCLES)) + 32'd1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_GAP    = 3'd2,
        S_PRESS2 = 3'd3,
        S_HELD   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               db_prev_q;
    logic               short_d, long_d, double_d, repeat_d;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state, counter and event decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        repeat_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // db_prev resets high, so a button held through reset never counts as a rise
                if (db && !db_prev_q) begin
                    state_d = S_PRESS1;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_PRESS1: begin
                if (db) begin
                    if (cnt_inc == CNT_W'(LONG_CYCLES)) begin
                        long_d  = 1'b1;
                        state_d = S_HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = S_GAP;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_GAP: begin
                // A new press wins even on the sample that would close the window
                if (db) begin
                    state_d = S_PRESS2;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_W'(GAP_CYCLES)) begin
                    short_d = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_PRESS2: begin
                if (!db) begin
                    double_d = 1'b1;
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                end
            end
            S_HELD: begin
                if (db) begin
                    if (cnt_inc == CNT_W'(REPEAT_CYCLES)) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            db_prev_q    <= 1'b1;
            pressed      <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            db_prev_q    <= db;
            pressed      <= db;
            short_press  <= short_d;
            long_press   <= long_d;
            double_press <= double_d;
            repeat_pulse <= repeat_d;
        end
    end

endmodule

// File: tb/tb_btn_press_decoder.sv
// tb_btn_press_decoder: directed and random stimulus for btn_press_decoder,
// checked every cycle against a run-length based reference model.
module tb_btn_press_decoder;

    localparam int LONG = 16;
    localparam int GAP  = 8;
    localparam int REP  = 4;

    logic clk = 1'b0;
    logic reset;
    logic db;
    logic pressed, short_press, long_press, double_press, repeat_pulse;

    int total = 0;
    int bad   = 0;

    // Reference model: samples of the press sequence currently being classified
    bit seq[$];
    bit active;
    bit prev_s;
    bit exp_pressed, exp_short, exp_long, exp_double, exp_rep;

    btn_press_decoder #(
        .LONG_CYCLES  (LONG),
        .GAP_CYCLES   (GAP),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .db          (db),
        .pressed     (pressed),
        .short_press (short_press),
        .long_press  (long_press),
        .double_press(double_press),
        .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        seq.delete();
        active      = 1'b0;
        prev_s      = 1'b1;
        exp_pressed = 1'b0;
        exp_short   = 1'b0;
        exp_long    = 1'b0;
        exp_double  = 1'b0;
        exp_rep     = 1'b0;
    endtask

    // Classify the sequence by its runs: high run r1, low run r0, high run r2
    task automatic model_analyze();
        int n;
        int i;
        int r1;
        int r0;
        int r2;
        n  = seq.size();
        i  = 0;
        r1 = 0;
        r0 = 0;
        r2 = 0;
        while (i < n && seq[i] == 1'b1) begin r1++; i++; end
        while (i < n && seq[i] == 1'b0) begin r0++; i++; end
        while (i < n && seq[i] == 1'b1) begin r2++; i++; end
        if (r1 == n) begin
            if (n == LONG) exp_long = 1'b1;
            else if (n > LONG && ((n - LONG) % REP) == 0) exp_rep = 1'b1;
        end else if (r1 >= LONG) begin
            active = 1'b0;
        end else if (r1 + r0 == n) begin
            if (r0 == GAP) begin
                exp_short = 1'b1;
                active    = 1'b0;
            end
        end else if (r1 + r0 + r2 < n) begin
            exp_double = 1'b1;
            active     = 1'b0;
        end
    endtask

    task automatic model_sample(input bit s);
        exp_short   = 1'b0;
        exp_long    = 1'b0;
        exp_double  = 1'b0;
        exp_rep     = 1'b0;
        exp_pressed = s;
        if (!active) begin
            if (s && !prev_s) begin
                active = 1'b1;
                seq.delete();
                seq.push_back(1'b1);
            end
        end else begin
            seq.push_back(s);
            model_analyze();
        end
        prev_s = s;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pressed"},      pressed,      exp_pressed);
        chk({tag, ".short_press"},  short_press,  exp_short);
        chk({tag, ".long_press"},   long_press,   exp_long);
        chk({tag, ".double_press"}, double_press, exp_double);
        chk({tag, ".repeat_pulse"}, repeat_pulse, exp_rep);
    endtask

    // Entered and left at a falling edge
    task automatic step(input bit d, input string tag);
        db = d;
        @(posedge clk);
        model_sample(d);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic run(input bit d, input int n, input string tag);
        for (int k = 0; k < n; k++) step(d, tag);
    endtask

    task automatic do_reset(input bit d);
        db    = d;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(negedge clk);
        check_all("in_reset");
        reset = 1'b0;
    endtask

    initial begin
        int len;
        bit lvl;
        reset = 1'b0;
        db    = 1'b1;
        model_reset();

        // Button held through reset is ignored until seen released
        do_reset(1'b1);
        run(1'b1, 40, "held_thru_reset");
        run(1'b0, 10, "held_release");

        // Short press
        run(1'b1, 5, "short_hi");
        run(1'b0, 8, "short_lo");
        run(1'b0, 3, "short_idle");

        // Long press with repeats, then release
        run(1'b1, 24, "long_hi");
        run(1'b0, 10, "long_release");

        // Double press
        run(1'b1, 3, "dbl_hi1");
        run(1'b0, 4, "dbl_lo1");
        run(1'b1, 3, "dbl_hi2");
        run(1'b0, 10, "dbl_lo2");

        // Gap boundary: 7 lows still inside the window
        run(1'b1, 3, "gap7_hi1");
        run(1'b0, 7, "gap7_lo1");
        run(1'b1, 2, "gap7_hi2");
        run(1'b0, 3, "gap7_lo2");

        // Gap boundary: 8 lows close the window, back-to-back rise
        run(1'b1, 3, "gap8_hi1");
        run(1'b0, 8, "gap8_lo1");
        run(1'b1, 2, "gap8_hi2");
        run(1'b0, 8, "gap8_lo2");

        // Reset mid-PRESS1 with db held high
        run(1'b1, 10, "rst_mid_hi");
        do_reset(1'b1);
        run(1'b1, 20, "rst_after_hi");
        run(1'b0, 2, "rst_after_lo");
        run(1'b1, 17, "rst_relong");
        run(1'b0, 10, "rst_relong_lo");

        // Random run lengths, occasionally interrupted by reset
        lvl = 1'b1;
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 15) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end
            if (lvl) len = int'($urandom_range(1, 30));
            else     len = int'($urandom_range(1, 12));
            run(lvl, len, "random");
            lvl = ~lvl;
        end
        run(1'b0, 12, "final_lo");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
